// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data SRAM port arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;

    // Which port owns the read data returning from the SRAM next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Source selected by the priority mux this cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_LD   = 2'd2,
        SRC_ST   = 2'd3
    } src_e;

    // Byte address to word index; callers cast down to the SRAM width (wraps)
    function automatic logic [29:0] byte2word(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/return buses plus the unified SRAM port.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 12
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          d_re;
    logic [31:0]   d_raddr;
    logic          d_we;
    logic [31:0]   d_waddr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_re, d_raddr, d_we, d_waddr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Core + SRAM view
    modport master (
        output if_req, if_addr, d_re, d_raddr, d_we, d_waddr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive denied fetch cycles; forces fetch to win once saturated.
module mem_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic if_gnt_i,
    output logic force_if_o
);
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturating increment while fetch waits; clear when granted or withdrawn
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STARVE_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if_o = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data load/store,
// granting one access per cycle and steering read data back to its owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 12,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    owner_e owner_q;
    owner_e owner_d;
    src_e   sel;
    logic   force_if;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (bus.if_req),
        .if_gnt_i   (bus.if_gnt),
        .force_if_o (force_if)
    );

    // Priority mux: starved fetch, then store, load, fetch; nothing while in reset
    always_comb begin
        sel = SRC_NONE;
        if (!rst_n) begin
            sel = SRC_NONE;
        end else if (force_if && bus.if_req) begin
            sel = SRC_IF;
        end else if (bus.d_we) begin
            sel = SRC_ST;
        end else if (bus.d_re) begin
            sel = SRC_LD;
        end else if (bus.if_req) begin
            sel = SRC_IF;
        end
    end

    // Grants, SRAM drive and next owner from the selected source
    always_comb begin
        owner_d       = OWN_NONE;
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (sel)
            SRC_IF: begin
                owner_d      = OWN_IF;
                bus.if_gnt   = 1'b1;
                bus.mem_en   = 1'b1;
                bus.mem_addr = AW'(byte2word(bus.if_addr));
            end
            SRC_LD: begin
                owner_d      = OWN_D;
                bus.d_gnt    = 1'b1;
                bus.mem_en   = 1'b1;
                bus.mem_addr = AW'(byte2word(bus.d_raddr));
            end
            SRC_ST: begin
                bus.d_gnt     = 1'b1;
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = AW'(byte2word(bus.d_waddr));
                bus.mem_wdata = bus.d_wdata;
            end
            default: ;
        endcase
    end

    // Owner of next cycle's SRAM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Return routing: data only to the owning port, zero otherwise
    always_comb begin
        bus.if_rvalid = (owner_q == OWN_IF);
        bus.d_rvalid  = (owner_q == OWN_D);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: grants checked per cycle, read returns via a scoreboard.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 12;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    rd_exp_t sb_q[$];
    logic [31:0] sram [0:(1<<AW)-1];

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(.AW(AW), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Write-first SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                sram[bus.mem_addr] <= bus.mem_wdata;
                bus.mem_rdata      <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= sram[bus.mem_addr];
            end
        end
    end

    function automatic logic [31:0] pat(input int idx);
        return 32'hA500_0000 | 32'(idx);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc_cnt);
        end
    endtask

    // Return monitor: pops scoreboard on every rvalid
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("rvalid_exclusive", 32'(bus.if_rvalid & bus.d_rvalid), 32'd0);
            if (!bus.if_rvalid) check_eq("if_rdata_zero", bus.if_rdata, 32'd0);
            if (!bus.d_rvalid)  check_eq("d_rdata_zero", bus.d_rdata, 32'd0);
            if (bus.if_rvalid || bus.d_rvalid) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    rd_exp_t e;
                    e = sb_q.pop_front();
                    check_eq("rd_port", 32'(bus.d_rvalid), 32'(e.is_d));
                    check_eq("rd_data", bus.d_rvalid ? bus.d_rdata : bus.if_rdata, e.data);
                    check_eq("rd_cycle", 32'(cyc_cnt), 32'(e.cyc));
                end
            end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc_cnt) begin
                check_eq("missing_rvalid", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic expect_rd(input bit is_d, input logic [31:0] data);
        rd_exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.cyc  = cyc_cnt + 1;
        sb_q.push_back(e);
    endtask

    // One cycle of stimulus, with expected grant and SRAM drive
    task automatic drive(input string tag,
                         input logic ifr, input logic [31:0] ia,
                         input logic dre, input logic [31:0] ra,
                         input logic dwe, input logic [31:0] wa, input logic [31:0] wd,
                         input logic eig, input logic edg, input logic ewe,
                         input logic [AW-1:0] ea);
        @(posedge clk);
        #1;
        bus.if_req  = ifr;  bus.if_addr = ia;
        bus.d_re    = dre;  bus.d_raddr = ra;
        bus.d_we    = dwe;  bus.d_waddr = wa;  bus.d_wdata = wd;
        @(negedge clk);
        check_eq({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'(eig));
        check_eq({tag, "_d_gnt"},  32'(bus.d_gnt),  32'(edg));
        check_eq({tag, "_mem_en"}, 32'(bus.mem_en), 32'(eig | edg));
        check_eq({tag, "_mem_we"}, 32'(bus.mem_we), 32'(ewe));
        check_eq({tag, "_mem_addr"}, 32'(bus.mem_addr), (eig | edg) ? 32'(ea) : 32'd0);
        check_eq({tag, "_mem_wdata"}, bus.mem_wdata, ewe ? wd : 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"},   32'({bus.if_gnt, bus.d_gnt}), 32'd0);
        check_eq({tag, "_rvalid"}, 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        check_eq({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        check_eq({tag, "_d_rdata"},  bus.d_rdata, 32'd0);
        check_eq({tag, "_mem_ctl"}, 32'({bus.mem_en, bus.mem_we}), 32'd0);
        check_eq({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = pat(i);
        sram[12'h011] = 32'h0000_0013;
        sram[12'h012] = 32'h0000_0022;
        bus.mem_rdata = '0;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.d_re = 1'b1;   bus.d_raddr = 32'h200;
        bus.d_we = 1'b1;   bus.d_waddr = 32'h100; bus.d_wdata = 32'h1;

        // Reset state with requests asserted
        #2;
        check_all_zero("reset");
        bus.if_req = 1'b0; bus.d_re = 1'b0; bus.d_we = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: single fetch
        drive("t1", 1, 32'h44, 0, 0, 0, 0, 0, 1, 0, 0, 12'h011);
        expect_rd(0, 32'h0000_0013);
        idle(1);

        // Upper and low address bits ignored
        drive("wrap", 1, 32'hFFFF_0047, 0, 0, 0, 0, 0, 1, 0, 0, 12'h011);
        expect_rd(0, 32'h0000_0013);

        // 2: store beats fetch, fetch next cycle
        drive("t2a", 1, 32'h48, 0, 0, 1, 32'h2000, 32'hDEAD_BEEF, 0, 1, 1, 12'h800);
        drive("t2b", 1, 32'h48, 0, 0, 0, 0, 0, 1, 0, 0, 12'h012);
        expect_rd(0, 32'h0000_0022);
        idle(1);

        // 3: fetch starved by loads is forced through on the 5th cycle
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                drive("t3_force", 1, 32'h44, 1, 32'h200, 0, 0, 0, 1, 0, 0, 12'h011);
                expect_rd(0, 32'h0000_0013);
            end else begin
                drive("t3_load", 1, 32'h44, 1, 32'h200, 0, 0, 0, 0, 1, 0, 12'h080);
                expect_rd(1, pat(12'h080));
            end
        end
        idle(1);

        // 4: store+load together, store first, load returns new data
        drive("t4a", 0, 0, 1, 32'h100, 1, 32'h100, 32'h5, 0, 1, 1, 12'h040);
        drive("t4b", 0, 0, 1, 32'h100, 0, 0, 0, 0, 1, 0, 12'h040);
        expect_rd(1, 32'h0000_0005);
        idle(1);

        // 5: reset in the cycle after a load grant drops the read
        drive("t5", 0, 0, 1, 32'h200, 0, 0, 0, 0, 1, 0, 12'h080);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.d_re = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h44;
        #1;
        check_all_zero("t5_rst");
        bus.if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 6: alternating fetch/load every cycle
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                drive("t6_if", 1, 32'(4 * (12'h020 + k)), 0, 0, 0, 0, 0, 1, 0, 0, AW'(12'h020 + k));
                expect_rd(0, pat(12'h020 + k));
            end else begin
                drive("t6_ld", 0, 0, 1, 32'(4 * (12'h100 + k)), 0, 0, 0, 0, 1, 0, AW'(12'h100 + k));
                expect_rd(1, pat(12'h100 + k));
            end
        end
        idle(3);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
